uart_loopback_seq: RTL and testbench
====================================

Name: uart_loopback_seq

Overview:
- Sequencer for the UART self-loopback test path.
- Requests NUM_BYTES bytes from the byte generator and launches each on the UART TX one at a time.
- Writes every byte the UART RX receives into the 8-bit FIFO.
- After the send phase, drains the FIFO and compares count and checksum of received bytes against sent bytes; reports pass/fail.

Parameters:
- NUM_BYTES, 256: bytes per test run (1..65535).
- RX_TIMEOUT, 200000: sys_clk cycles to wait for outstanding RX bytes after the last TX completes.
- RESTART_GAP, 1000: idle cycles before auto-restart (optional feature only).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse, begins a run; honoured only in IDLE or DONE.
- gen_en  out  1  request to generator; held until gen_ok.
- gen_ok  in  1  one-cycle pulse, gen_data valid.
- gen_data  in  8  generated byte.
- tx_en  out  1  one-cycle TX launch pulse.
- tx_din  out  8  TX byte, stable from tx_en until tx_busy falls.
- tx_busy  in  1  TX in progress; rises 1-2 cycles after tx_en.
- rx_done  in  1  one-cycle pulse, rx_data valid.
- rx_data  in  8  received byte.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  8  FIFO write data.
- fifo_full  in  1  FIFO full.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rd_data  in  8  FIFO read data, valid 1 cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty.
- busy  out  1  run in progress (state not IDLE/DONE).
- done  out  1  one-cycle pulse on entering DONE.
- pass  out  1  result of last run, held until next start.
- tx_cnt  out  16  bytes launched this run.
- rx_cnt  out  16  bytes written to FIFO this run.
- drop_cnt  out  16  RX bytes dropped because FIFO full.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters and checksums 0.
- start clears tx_cnt, rx_cnt, drop_cnt, pass, tx_sum, rd_sum, rd_cnt; then GEN.
- GEN:
  - gen_en=1.
  - On gen_ok: capture gen_data into tx_din; tx_en=1 next cycle; tx_sum += gen_data (16-bit, mod 2^16); tx_cnt+1; go to TX_ARM.
- TX_ARM: wait for tx_busy=1. If it does not rise within 4 cycles, go to TX_WAIT anyway.
- TX_WAIT: on tx_busy=0 go to GEN if tx_cnt<NUM_BYTES, else RX_WAIT with the timeout counter cleared.
- RX capture runs in every state except IDLE/DONE:
  - rx_done with fifo_full=0: fifo_wr_en=1 and fifo_wr_data=rx_data one cycle later (registered); rx_cnt+1.
  - rx_done with fifo_full=1: no write; drop_cnt+1.
  - Counters saturate at 0xFFFF.
- RX_WAIT: go to DRAIN when rx_cnt+drop_cnt==NUM_BYTES or the timeout counter reaches RX_TIMEOUT-1.
- DRAIN:
  - Assert fifo_rd_en whenever fifo_empty=0 (one read per cycle allowed).
  - Each fifo_rd_data returned 1 cycle later: rd_sum += byte; rd_cnt+1.
  - Leave when fifo_empty=1 and no read is outstanding; go to DONE.
- Reads never issue while fifo_empty=1. Writes never issue while fifo_full=1.
- DONE:
  - done pulses 1 cycle.
  - pass = (rd_cnt==NUM_BYTES) && (drop_cnt==0) && (rd_sum==tx_sum).
  - Stay in DONE; start returns to GEN with counters cleared.
- start while busy=1: ignored.
- sys_rst mid-run: immediate return to IDLE and all outputs 0, including any pending tx_en, fifo_wr_en and fifo_rd_en. Bytes already in the FIFO are not flushed by this block.
- rx_done coincident with a state transition is never lost: capture is independent of the FSM.

Optional Feature:
- Macro: LBK_AUTO_RESTART_EN.
- Defined: after RESTART_GAP cycles in DONE, the block self-starts a new run (same as a start pulse). An external start during the gap starts immediately.
- Undefined: DONE is held until start; RESTART_GAP unused.

Test Plan:
- NUM_BYTES=4, generator 0x11,0x22,0x33,0x44, TX looped to RX -> 4 tx_en pulses, 4 FIFO writes, 4 reads, tx_sum=rd_sum=0x00AA, pass=1, done pulse once.
- NUM_BYTES=256 loopback, generator 0x00..0xFF -> tx_cnt=rx_cnt=256, sum 0x7F80, pass=1, fifo_empty=1 at DONE.
- RX line corrupts byte 3 (0x33 received as 0x32) -> counts match, rd_sum=0x00A9, pass=0.
- RX disconnected, RX_TIMEOUT=100 -> DRAIN entered 100 cycles after last TX, rd_cnt=0, pass=0.
- fifo_full forced high during 2 rx_done pulses -> drop_cnt=2, no fifo_wr_en during them, pass=0.
- sys_rst for 1 cycle mid-TX of byte 2, then start -> all outputs 0 after reset, new run counts from 0. Separately: start pulse during a run -> no effect on counts.

Source files
------------

// File: rtl/uart_loopback_seq_if.sv
// ---------------------------------------------------------------------------
// uart_loopback_seq_if
// Bundles the peripheral-facing signals of the UART loopback sequencer:
//   generator : gen_en (seq->gen), gen_ok / gen_data (gen->seq)
//   UART TX   : tx_en / tx_din (seq->tx), tx_busy (tx->seq)
//   UART RX   : rx_done / rx_data (rx->seq)
//   FIFO      : fifo_wr_en / fifo_wr_data / fifo_rd_en (seq->fifo),
//               fifo_full / fifo_empty / fifo_rd_data (fifo->seq)
// master = sequencer side, slave = environment (generator, UART, FIFO).
// ---------------------------------------------------------------------------
interface uart_loopback_seq_if;
  logic       gen_en;
  logic       gen_ok;
  logic [7:0] gen_data;
  logic       tx_en;
  logic [7:0] tx_din;
  logic       tx_busy;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       fifo_full;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       fifo_empty;

  modport master (
    output gen_en, tx_en, tx_din, fifo_wr_en, fifo_wr_data, fifo_rd_en,
    input  gen_ok, gen_data, tx_busy, rx_done, rx_data,
           fifo_full, fifo_rd_data, fifo_empty
  );

  modport slave (
    input  gen_en, tx_en, tx_din, fifo_wr_en, fifo_wr_data, fifo_rd_en,
    output gen_ok, gen_data, tx_busy, rx_done, rx_data,
           fifo_full, fifo_rd_data, fifo_empty
  );
endinterface

// File: rtl/uart_loopback_seq.sv
// ---------------------------------------------------------------------------
// uart_loopback_seq
// Sequencer for the UART self-loopback test. Pulls NUM_BYTES bytes from the
// byte generator, launches them one at a time on the UART TX, writes every
// byte the UART RX returns into an 8-bit FIFO, then drains the FIFO and
// compares count/checksum of received bytes against the sent ones.
//
// Ports:
//   i_sys_clk   system clock
//   i_sys_rst   synchronous active-high reset
//   i_start     one-cycle run start (honoured only in IDLE/DONE)
//   io_bus      generator / UART TX / UART RX / FIFO signals (master side)
//   o_busy      run in progress
//   o_done      one-cycle pulse on entering DONE
//   o_pass      result of the last run, held until the next start
//   o_tx_cnt    bytes launched this run
//   o_rx_cnt    bytes written to the FIFO this run
//   o_drop_cnt  RX bytes dropped because the FIFO was full
//
// Build option: define LBK_AUTO_RESTART_EN to self-start a new run after
// RESTART_GAP cycles in DONE. Without it DONE is held until i_start.
// ---------------------------------------------------------------------------
module uart_loopback_seq #(
  parameter int NUM_BYTES   = 256,
  parameter int RX_TIMEOUT  = 200000,
  parameter int RESTART_GAP = 1000
) (
  input  logic                       i_sys_clk,
  input  logic                       i_sys_rst,
  input  logic                       i_start,
  uart_loopback_seq_if.master        io_bus,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_pass,
  output logic [15:0]                o_tx_cnt,
  output logic [15:0]                o_rx_cnt,
  output logic [15:0]                o_drop_cnt
);

  localparam logic [15:0] LP_NUM      = 16'(NUM_BYTES);
  localparam logic [31:0] LP_TMO_LAST = 32'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_TX_ARM, S_TX_WAIT, S_RX_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t      r_state, w_next;

  logic        r_tx_en;
  logic [7:0]  r_tx_din;
  logic [15:0] r_tx_sum, r_tx_cnt;
  logic [1:0]  r_arm_cnt;
  logic [31:0] r_tmo_cnt;
  logic        r_wr_en;
  logic [7:0]  r_wr_data;
  logic [15:0] r_rx_cnt, r_drop_cnt;
  logic        r_rd_pend;
  logic [15:0] r_rd_sum, r_rd_cnt;
  logic        r_done, r_pass;

  logic        w_run, w_go, w_auto_start, w_rd_en, w_pass_eval, w_enter_done;
  logic [16:0] w_rx_total;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_run        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_go         = (i_start || w_auto_start) && !w_run;
  // One read per cycle while data is available; never while empty.
  assign w_rd_en      = (r_state == S_DRAIN) && !io_bus.fifo_empty;
  assign w_rx_total   = {1'b0, r_rx_cnt} + {1'b0, r_drop_cnt};
  assign w_pass_eval  = (r_rd_cnt == LP_NUM) && (r_drop_cnt == 16'd0) &&
                        (r_rd_sum == r_tx_sum);
  assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);

  // -------------------------------------------------------------------------
  // Optional self-restart after a gap in DONE
  // -------------------------------------------------------------------------
`ifdef LBK_AUTO_RESTART_EN
  logic [31:0] r_gap_cnt;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst)                      r_gap_cnt <= '0;
    else if (r_state == S_DONE && !w_go) r_gap_cnt <= r_gap_cnt + 32'd1;
    else                                r_gap_cnt <= '0;
  end

  assign w_auto_start = (r_state == S_DONE) &&
                        (r_gap_cnt == 32'(RESTART_GAP - 1));
`else
  logic [31:0] w_unused_gap;
  assign w_unused_gap = 32'(RESTART_GAP);
  assign w_auto_start = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_go) w_next = S_GEN;
      S_GEN:     if (io_bus.gen_ok) w_next = S_TX_ARM;
      // Fall through to TX_WAIT if busy never shows, so a dead TX cannot hang us.
      S_TX_ARM:  if (io_bus.tx_busy || r_arm_cnt == 2'd3) w_next = S_TX_WAIT;
      S_TX_WAIT: if (!io_bus.tx_busy)
                   w_next = (r_tx_cnt < LP_NUM) ? S_GEN : S_RX_WAIT;
      S_RX_WAIT: if (w_rx_total >= {1'b0, LP_NUM} || r_tmo_cnt >= LP_TMO_LAST)
                   w_next = S_DRAIN;
      // A write still in the output register has not reached the FIFO yet,
      // so fifo_empty alone is not enough to declare the drain finished.
      S_DRAIN:   if (io_bus.fifo_empty && !r_rd_pend && !r_wr_en) w_next = S_DONE;
      S_DONE:    if (w_go) w_next = S_GEN;
      default:   w_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // TX path: capture generated byte, launch pulse, sent checksum
  // -------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_tx_en   <= 1'b0;
      r_tx_din  <= '0;
      r_tx_sum  <= '0;
      r_tx_cnt  <= '0;
      r_arm_cnt <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_tx_en   <= 1'b0;
      r_arm_cnt <= (r_state == S_TX_ARM)  ? r_arm_cnt + 2'd1  : 2'd0;
      r_tmo_cnt <= (r_state == S_RX_WAIT) ? r_tmo_cnt + 32'd1 : 32'd0;
      if (w_go) begin
        r_tx_sum <= '0;
        r_tx_cnt <= '0;
      end else if (r_state == S_GEN && io_bus.gen_ok) begin
        r_tx_din <= io_bus.gen_data;
        r_tx_en  <= 1'b1;
        r_tx_sum <= r_tx_sum + {8'h00, io_bus.gen_data};
        r_tx_cnt <= sat_inc(r_tx_cnt);
      end
    end
  end

  // -------------------------------------------------------------------------
  // RX capture: independent of the FSM so a byte arriving on a state change
  // is still taken. Active whenever a run is in progress.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_go) begin
        r_rx_cnt   <= '0;
        r_drop_cnt <= '0;
      end else if (w_run && io_bus.rx_done) begin
        if (!io_bus.fifo_full) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= io_bus.rx_data;
          r_rx_cnt  <= sat_inc(r_rx_cnt);
        end else begin
          r_drop_cnt <= sat_inc(r_drop_cnt);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Drain: read data arrives one cycle after the strobe
  // -------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_rd_pend <= 1'b0;
      r_rd_sum  <= '0;
      r_rd_cnt  <= '0;
    end else begin
      r_rd_pend <= w_rd_en;
      if (w_go) begin
        r_rd_sum <= '0;
        r_rd_cnt <= '0;
      end else if (r_rd_pend) begin
        r_rd_sum <= r_rd_sum + {8'h00, io_bus.fifo_rd_data};
        r_rd_cnt <= sat_inc(r_rd_cnt);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Result
  // -------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_done <= w_enter_done;
      if (w_go)              r_pass <= 1'b0;
      else if (w_enter_done) r_pass <= w_pass_eval;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign io_bus.gen_en       = (r_state == S_GEN);
  assign io_bus.tx_en        = r_tx_en;
  assign io_bus.tx_din       = r_tx_din;
  assign io_bus.fifo_wr_en   = r_wr_en;
  assign io_bus.fifo_wr_data = r_wr_data;
  assign io_bus.fifo_rd_en   = w_rd_en;

  assign o_busy     = w_run;
  assign o_done     = r_done;
  assign o_pass     = r_pass;
  assign o_tx_cnt   = r_tx_cnt;
  assign o_rx_cnt   = r_rx_cnt;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_loopback_seq.sv
// ---------------------------------------------------------------------------
// Testbench for uart_loopback_seq (NUM_BYTES=4, RX_TIMEOUT=100).
// Environment models: byte generator, UART TX with loopback into RX (with an
// optional corrupted byte), and a queue-based FIFO with forced-full control.
// ---------------------------------------------------------------------------
module tb_uart_loopback_seq;
  localparam int NB    = 4;
  localparam int TMO   = 100;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  uart_loopback_seq_if bus ();

  logic        busy, done, pass;
  logic [15:0] tx_cnt, rx_cnt, drop_cnt;

  uart_loopback_seq #(.NUM_BYTES(NB), .RX_TIMEOUT(TMO), .RESTART_GAP(50)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_start(start), .io_bus(bus),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_tx_cnt(tx_cnt), .o_rx_cnt(rx_cnt), .o_drop_cnt(drop_cnt)
  );

  // Environment controls, written only by the test sequence
  logic [7:0]  pat [4];
  logic        loop_en     = 1'b1;
  int          corrupt_idx = -1;
  logic [31:0] full_mask   = '0;
  logic        flush       = 1'b0;

  // Generator: one gen_ok pulse per request
  int gen_idx = 0;
  always @(posedge clk) begin
    if (rst) bus.gen_ok <= 1'b0;
    else begin
      bus.gen_ok <= 1'b0;
      if (start && !busy) gen_idx <= 0;
      else if (bus.gen_en && !bus.gen_ok) begin
        bus.gen_ok   <= 1'b1;
        bus.gen_data <= pat[gen_idx % 4];
        gen_idx      <= gen_idx + 1;
      end
    end
  end

  // UART TX, busy 8 cycles starting 2 cycles after tx_en; looped byte
  // appears on RX as busy falls.
  int         tx_timer = 0;
  int         rx_idx   = 0;
  logic [7:0] tx_latch;
  always @(posedge clk) begin
    bus.rx_done <= 1'b0;
    if (start && !busy) rx_idx <= 0;
    if (bus.tx_en === 1'b1) begin
      tx_latch <= bus.tx_din;
      tx_timer <= 9;
    end else if (tx_timer != 0) begin
      tx_timer <= tx_timer - 1;
      if (tx_timer == 1 && loop_en) begin
        bus.rx_done <= 1'b1;
        bus.rx_data <= (rx_idx == corrupt_idx) ? tx_latch - 8'd1 : tx_latch;
        rx_idx      <= rx_idx + 1;
      end
    end
  end
  assign bus.tx_busy = (tx_timer >= 1) && (tx_timer <= 8);

  // FIFO model
  logic [7:0] fq [$];
  int         fcnt = 0;
  always @(posedge clk) begin
    if (flush) fq.delete();
    else begin
      if (bus.fifo_rd_en === 1'b1 && fq.size() > 0) bus.fifo_rd_data <= fq.pop_front();
      if (bus.fifo_wr_en === 1'b1) fq.push_back(bus.fifo_wr_data);
    end
    fcnt <= fq.size();
  end
  assign bus.fifo_empty = (fcnt == 0);
  assign bus.fifo_full  = (fcnt >= DEPTH) || (bus.rx_done && full_mask[rx_idx[4:0]]);

  // Scoreboard and statistics (owned by the test sequence)
  logic [7:0] exp_tx_q [$];
  logic [7:0] exp_wr_q [$];
  int checks = 0, errors = 0;
  int n_tx = 0, n_wr = 0, n_rd = 0, n_done = 0, cyc = 0;

  task automatic step();
    logic [7:0] e;
    @(posedge clk); #1;
    cyc++;
    if (bus.gen_ok && bus.gen_en) exp_tx_q.push_back(bus.gen_data);
    if (bus.tx_en) begin
      n_tx++; checks++;
      if (exp_tx_q.size() == 0) begin
        errors++; $display("FAIL tx_en_unexpected got tx_din=%02h expected no launch", bus.tx_din);
      end else begin
        e = exp_tx_q.pop_front();
        if (bus.tx_din !== e) begin
          errors++; $display("FAIL tx_din got %02h expected %02h", bus.tx_din, e);
        end
      end
    end
    if (bus.rx_done && busy && !bus.fifo_full) exp_wr_q.push_back(bus.rx_data);
    if (bus.fifo_wr_en) begin
      n_wr++; checks++;
      if (exp_wr_q.size() == 0 || bus.fifo_full) begin
        errors++; $display("FAIL fifo_wr_unexpected got wr_data=%02h full=%0b expected no write",
                           bus.fifo_wr_data, bus.fifo_full);
      end else begin
        e = exp_wr_q.pop_front();
        if (bus.fifo_wr_data !== e) begin
          errors++; $display("FAIL fifo_wr_data got %02h expected %02h", bus.fifo_wr_data, e);
        end
      end
    end
    if (bus.fifo_rd_en) begin
      n_rd++; checks++;
      if (bus.fifo_empty !== 1'b0) begin
        errors++; $display("FAIL rd_while_empty got empty=%0b expected 0", bus.fifo_empty);
      end
    end
    if (done) n_done++;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic set_pat(input logic [7:0] a, b, c, d);
    pat[0] = a; pat[1] = b; pat[2] = c; pat[3] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({busy, done, pass, bus.gen_en, bus.tx_en, bus.fifo_wr_en, bus.fifo_rd_en} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b expected 0000000",
        {busy, done, pass, bus.gen_en, bus.tx_en, bus.fifo_wr_en, bus.fifo_rd_en});
    end
    checks++;
    if ({tx_cnt, rx_cnt, drop_cnt} !== 48'h0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d/%0d expected 0/0/0", tx_cnt, rx_cnt, drop_cnt);
    end
    checks++;
    if ({bus.tx_din, bus.fifo_wr_data} !== 16'h0) begin
      errors++; $display("FAIL reset_data got %04h expected 0000", {bus.tx_din, bus.fifo_wr_data});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_loopback();
    int b_tx, b_wr, b_rd, b_dn; bit seen;
    set_pat(8'h11, 8'h22, 8'h33, 8'h44);
    loop_en = 1'b1; corrupt_idx = -1; full_mask = '0;
    b_tx = n_tx; b_wr = n_wr; b_rd = n_rd; b_dn = n_done;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy got %0b expected 1", busy); end
    run_to_done(2000, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL loop_done_timeout got no done expected done"); end
    checks++;
    if (pass !== 1'b1) begin errors++; $display("FAIL loop_pass got %0b expected 1", pass); end
    checks++;
    if (tx_cnt !== 16'd4 || rx_cnt !== 16'd4 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL loop_counts got %0d/%0d/%0d expected 4/4/0", tx_cnt, rx_cnt, drop_cnt);
    end
    checks++;
    if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL loop_fifo_empty got %0b expected 1", bus.fifo_empty); end
    repeat (3) step();
    checks++;
    if (n_tx - b_tx != 4 || n_wr - b_wr != 4 || n_rd - b_rd != 4) begin
      errors++; $display("FAIL loop_strobes got tx=%0d wr=%0d rd=%0d expected 4/4/4",
                         n_tx - b_tx, n_wr - b_wr, n_rd - b_rd);
    end
    checks++;
    if (n_done - b_dn != 1) begin errors++; $display("FAIL loop_done_pulses got %0d expected 1", n_done - b_dn); end
    checks++;
    if (busy !== 1'b0 || pass !== 1'b1 || bus.gen_en !== 1'b0) begin
      errors++; $display("FAIL loop_hold got busy=%0b pass=%0b gen_en=%0b expected 0/1/0", busy, pass, bus.gen_en);
    end
    checks++;
    if (exp_tx_q.size() != 0 || exp_wr_q.size() != 0) begin
      errors++; $display("FAIL loop_scoreboard_left got %0d/%0d expected 0/0", exp_tx_q.size(), exp_wr_q.size());
    end
  endtask

  task automatic test_corrupt();
    bit seen;
    set_pat(8'h11, 8'h22, 8'h33, 8'h44);
    corrupt_idx = 2;  // 0x33 arrives as 0x32: read sum 0xA9 vs sent 0xAA
    pulse_start();
    checks++;
    if (pass !== 1'b0 || tx_cnt !== 16'd0) begin
      errors++; $display("FAIL corrupt_start_clear got pass=%0b tx_cnt=%0d expected 0/0", pass, tx_cnt);
    end
    run_to_done(2000, seen);
    checks++;
    if (!seen || pass !== 1'b0) begin
      errors++; $display("FAIL corrupt_pass got done=%0b pass=%0b expected 1/0", seen, pass);
    end
    checks++;
    if (tx_cnt !== 16'd4 || rx_cnt !== 16'd4 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL corrupt_counts got %0d/%0d/%0d expected 4/4/0", tx_cnt, rx_cnt, drop_cnt);
    end
    corrupt_idx = -1;
    repeat (2) step();
  endtask

  task automatic test_timeout();
    int b_wr, b_rd, fall_cyc; bit seen, prev_busy;
    loop_en = 1'b0; fall_cyc = -1; prev_busy = 1'b0; seen = 1'b0;
    b_wr = n_wr; b_rd = n_rd;
    pulse_start();
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      if (prev_busy && !bus.tx_busy && tx_cnt == 16'd4) fall_cyc = cyc;
      prev_busy = bus.tx_busy;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || pass !== 1'b0) begin
      errors++; $display("FAIL timeout_pass got done=%0b pass=%0b expected 1/0", seen, pass);
    end
    // DUT sees busy low one edge later, waits 100 cycles, then DRAIN (1) -> DONE
    checks++;
    if (cyc - fall_cyc != TMO + 2) begin
      errors++; $display("FAIL timeout_latency got %0d expected %0d", cyc - fall_cyc, TMO + 2);
    end
    checks++;
    if (rx_cnt !== 16'd0 || n_wr != b_wr || n_rd != b_rd) begin
      errors++; $display("FAIL timeout_rx got rx_cnt=%0d wr=%0d rd=%0d expected 0/0/0",
                         rx_cnt, n_wr - b_wr, n_rd - b_rd);
    end
    loop_en = 1'b1;
  endtask

  task automatic test_drop();
    int b_wr, b_rd; bit seen;
    full_mask = 32'b0110;  // bytes 1 and 2 meet a full FIFO
    b_wr = n_wr; b_rd = n_rd;
    pulse_start();
    run_to_done(2000, seen);
    checks++;
    if (!seen || pass !== 1'b0) begin
      errors++; $display("FAIL drop_pass got done=%0b pass=%0b expected 1/0", seen, pass);
    end
    checks++;
    if (drop_cnt !== 16'd2 || rx_cnt !== 16'd2 || tx_cnt !== 16'd4) begin
      errors++; $display("FAIL drop_counts got drop=%0d rx=%0d tx=%0d expected 2/2/4", drop_cnt, rx_cnt, tx_cnt);
    end
    checks++;
    if (n_wr - b_wr != 2 || n_rd - b_rd != 2) begin
      errors++; $display("FAIL drop_strobes got wr=%0d rd=%0d expected 2/2", n_wr - b_wr, n_rd - b_rd);
    end
    full_mask = '0;
  endtask

  task automatic test_reset_midrun();
    bit seen, hit; int b_dn;
    hit = 1'b0;
    pulse_start();
    for (int i = 0; i < 500 && !hit; i++) begin
      step();
      if (tx_cnt == 16'd2 && bus.tx_busy) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midrun_reach got no byte-2 TX expected one"); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if ({busy, done, pass, bus.gen_en, bus.tx_en, bus.fifo_wr_en, bus.fifo_rd_en} !== 7'b0 ||
        {tx_cnt, rx_cnt, drop_cnt} !== 48'h0) begin
      errors++; $display("FAIL midrun_reset_outputs got flags=%b counts=%0d/%0d/%0d expected all 0",
        {busy, done, pass, bus.gen_en, bus.tx_en, bus.fifo_wr_en, bus.fifo_rd_en}, tx_cnt, rx_cnt, drop_cnt);
    end
    for (int i = 0; i < 50 && bus.tx_busy; i++) step();
    repeat (3) step();
    flush = 1'b1; step(); flush = 1'b0; step();
    exp_tx_q.delete(); exp_wr_q.delete();
    b_dn = n_done;
    pulse_start();
    run_to_done(2000, seen);
    checks++;
    if (!seen || pass !== 1'b1 || tx_cnt !== 16'd4 || rx_cnt !== 16'd4) begin
      errors++; $display("FAIL midrun_rerun got done=%0b pass=%0b tx=%0d rx=%0d expected 1/1/4/4",
                         seen, pass, tx_cnt, rx_cnt);
    end
    step();
    checks++;
    if (n_done - b_dn != 1) begin errors++; $display("FAIL midrun_done_pulses got %0d expected 1", n_done - b_dn); end
  endtask

  task automatic test_start_ignored();
    logic [15:0] snap; bit seen;
    set_pat(8'hF0, 8'h0F, 8'hA5, 8'h5A);
    pulse_start();
    repeat (20) step();
    snap = tx_cnt;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || tx_cnt !== snap) begin
      errors++; $display("FAIL start_busy got busy=%0b tx_cnt=%0d expected 1/%0d", busy, tx_cnt, snap);
    end
    run_to_done(2000, seen);
    checks++;
    if (!seen || pass !== 1'b1 || tx_cnt !== 16'd4 || rx_cnt !== 16'd4) begin
      errors++; $display("FAIL start_ignored_run got done=%0b pass=%0b tx=%0d rx=%0d expected 1/1/4/4",
                         seen, pass, tx_cnt, rx_cnt);
    end
  endtask

  initial begin
    set_pat(8'h11, 8'h22, 8'h33, 8'h44);
    test_reset();
    test_loopback();
    test_corrupt();
    test_timeout();
    test_drop();
    test_reset_midrun();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
